// File: rtl/spi_xfer_scheduler.sv
// Round-robin scheduler sharing one SPI master/slave platform between two byte
// requesters: grant, run until both end flags, return the received byte, then idle gap.
module spi_xfer_scheduler #(
    parameter int GAP_CYC     = 10,
    parameter int TIMEOUT_CYC = 1024,
    parameter int TO_W        = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       im_req_a,
    input  logic [7:0] im_txd_a,
    input  logic       im_req_b,
    input  logic [7:0] im_txd_b,
    output logic       om_ack_a,
    output logic       om_ack_b,
    output logic [7:0] om_rdata,
    output logic       om_rvalid_a,
    output logic       om_rvalid_b,
    output logic       om_err,
    output logic       om_busy,
    output logic       om_work_en,
    output logic [7:0] om_data_bus_master,
    input  logic       im_work_end_master,
    input  logic       im_work_end_slave,
    input  logic [7:0] im_data_bus_master
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

    state_t           r_state, w_state_nxt;
    logic [TO_W-1:0]  r_to_cnt, w_to_cnt_nxt;
    logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_nxt;
    logic             r_prio_b, w_prio_b_nxt;
    logic             r_owner_b, w_owner_b_nxt;
    logic [7:0]       r_tx, w_tx_nxt;
    logic [7:0]       r_rdata, w_rdata_nxt;
    logic             r_ack_a, w_ack_a_nxt;
    logic             r_ack_b, w_ack_b_nxt;
    logic             r_rvalid_a, w_rvalid_a_nxt;
    logic             r_rvalid_b, w_rvalid_b_nxt;
    logic             r_err, w_err_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_work_en, w_work_en_nxt;
    logic             w_win_a, w_win_b, w_done;

    // r_prio_b set means B was not granted last, so B wins a tie.
    assign w_win_a = im_req_a & (~im_req_b | ~r_prio_b);
    assign w_win_b = im_req_b & (~im_req_a |  r_prio_b);
    assign w_done  = im_work_end_master & im_work_end_slave;

    always_comb begin
        w_state_nxt    = r_state;
        w_to_cnt_nxt   = r_to_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_prio_b_nxt   = r_prio_b;
        w_owner_b_nxt  = r_owner_b;
        w_tx_nxt       = r_tx;
        w_rdata_nxt    = r_rdata;
        w_ack_a_nxt    = 1'b0;
        w_ack_b_nxt    = 1'b0;
        w_rvalid_a_nxt = 1'b0;
        w_rvalid_b_nxt = 1'b0;
        w_err_nxt      = 1'b0;
        w_busy_nxt     = r_busy;
        w_work_en_nxt  = r_work_en;
        case (r_state)
            S_IDLE: begin
                if (w_win_a || w_win_b) begin
                    w_tx_nxt      = w_win_a ? im_txd_a : im_txd_b;
                    w_owner_b_nxt = w_win_b;
                    w_prio_b_nxt  = w_win_a;
                    w_ack_a_nxt   = w_win_a;
                    w_ack_b_nxt   = w_win_b;
                    w_work_en_nxt = 1'b1;
                    w_busy_nxt    = 1'b1;
                    w_to_cnt_nxt  = '0;
                    w_state_nxt   = S_RUN;
                end
            end
            S_RUN: begin
                w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                // Completion is checked first so it beats a coincident timeout.
                if (w_done) begin
                    w_rdata_nxt    = im_data_bus_master;
                    w_rvalid_a_nxt = ~r_owner_b;
                    w_rvalid_b_nxt = r_owner_b;
                    w_work_en_nxt  = 1'b0;
                    w_gap_cnt_nxt  = '0;
                    w_state_nxt    = S_GAP;
                end else if (r_to_cnt == TO_LAST) begin
                    w_err_nxt     = 1'b1;
                    w_work_en_nxt = 1'b0;
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt != GAP_LAST) begin
                    w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
                end else if (!im_work_end_master && !im_work_end_slave) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_busy_nxt    = 1'b0;
                w_work_en_nxt = 1'b0;
                w_state_nxt   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_to_cnt   <= '0;
            r_gap_cnt  <= '0;
            r_prio_b   <= 1'b0;
            r_owner_b  <= 1'b0;
            r_tx       <= '0;
            r_rdata    <= '0;
            r_ack_a    <= 1'b0;
            r_ack_b    <= 1'b0;
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_work_en  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_prio_b   <= w_prio_b_nxt;
            r_owner_b  <= w_owner_b_nxt;
            r_tx       <= w_tx_nxt;
            r_rdata    <= w_rdata_nxt;
            r_ack_a    <= w_ack_a_nxt;
            r_ack_b    <= w_ack_b_nxt;
            r_rvalid_a <= w_rvalid_a_nxt;
            r_rvalid_b <= w_rvalid_b_nxt;
            r_err      <= w_err_nxt;
            r_busy     <= w_busy_nxt;
            r_work_en  <= w_work_en_nxt;
        end
    end

    assign om_ack_a           = r_ack_a;
    assign om_ack_b           = r_ack_b;
    assign om_rdata           = r_rdata;
    assign om_rvalid_a        = r_rvalid_a;
    assign om_rvalid_b        = r_rvalid_b;
    assign om_err             = r_err;
    assign om_busy            = r_busy;
    assign om_work_en         = r_work_en;
    assign om_data_bus_master = r_tx;

endmodule
